// File: rtl/work_stealing_scheduler_rr.sv
`default_nettype none
// ============================================================================
// Module      : work_stealing_scheduler_rr
// Description : Round-robin victim/thief work-stealing scheduler for the BFS
//               PU array with valid/ready offer, timeout and cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module work_stealing_scheduler_rr #(
    parameter int NUM_PU            = 16,
    parameter int QUEUE_DEPTH_WIDTH = 10,
    parameter int MAX_STEAL         = 64,
    parameter int TIMEOUT_CYCLES    = 256,
    parameter int COOLDOWN_CYCLES   = 8,
    localparam int IDXW             = (NUM_PU > 2) ? $clog2(NUM_PU) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [NUM_PU*QUEUE_DEPTH_WIDTH-1:0] pe_queue_depths,
    input  logic [QUEUE_DEPTH_WIDTH-1:0]        dynamic_threshold,
    output logic                                steal_valid,
    input  logic                                steal_ready,
    output logic [IDXW-1:0]                     steal_from,
    output logic [IDXW-1:0]                     steal_to,
    output logic [QUEUE_DEPTH_WIDTH-1:0]        steal_amount,
    input  logic                                steal_done,
    output logic                                steal_timeout,
    output logic [31:0]                         steal_count,
    output logic                                busy
);

    localparam int QDW       = QUEUE_DEPTH_WIDTH;
    localparam int c_TMR_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_CD_LAST  = c_TMR_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic [QDW-1:0]     c_MAX_STEAL = QDW'(MAX_STEAL);
    localparam logic [IDXW-1:0]    c_LAST_IDX  = IDXW'(NUM_PU - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_OFFER     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_COOLDOWN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDXW-1:0]     r_victim_ptr;
    logic [IDXW-1:0]     r_thief_ptr;
    logic [c_TMR_W-1:0]  r_timer;
    logic [IDXW-1:0]     r_steal_from;
    logic [IDXW-1:0]     r_steal_to;
    logic [QDW-1:0]      r_steal_amount;
    logic                r_steal_timeout;
    logic [31:0]         r_steal_count;

    logic [QDW-1:0]      w_depth [NUM_PU];
    logic [NUM_PU-1:0]   w_is_victim;
    logic [NUM_PU-1:0]   w_is_thief;
    logic [IDXW:0]       w_victim_pick;
    logic [IDXW:0]       w_thief_pick;
    logic [IDXW-1:0]     w_victim_idx;
    logic [QDW-1:0]      w_half;
    logic [QDW-1:0]      w_amount;
    logic                w_load;
    logic                w_accept;
    logic                w_done_hit;
    logic                w_timeout_hit;

    generate
        for (genvar k = 0; k < NUM_PU; k++) begin : g_cand
            assign w_depth[k]     = pe_queue_depths[k*QDW +: QDW];
            assign w_is_victim[k] = (w_depth[k] > dynamic_threshold) && (w_depth[k] >= QDW'(2));
            assign w_is_thief[k]  = (w_depth[k] == '0);
        end
    endgenerate

    // First candidate at index >= ptr, otherwise the lowest candidate (wrap).
    function automatic logic [IDXW:0] rr_pick(input logic [NUM_PU-1:0] cand,
                                              input logic [IDXW-1:0]   ptr);
        logic            hi_f;
        logic            lo_f;
        logic [IDXW-1:0] hi_i;
        logic [IDXW-1:0] lo_i;
        hi_f = 1'b0;
        lo_f = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int k = NUM_PU - 1; k >= 0; k--) begin
            if (cand[k]) begin
                lo_f = 1'b1;
                lo_i = IDXW'(k);
                if (IDXW'(k) >= ptr) begin
                    hi_f = 1'b1;
                    hi_i = IDXW'(k);
                end
            end
        end
        return {lo_f, (hi_f ? hi_i : lo_i)};
    endfunction

    assign w_victim_pick = rr_pick(w_is_victim, r_victim_ptr);
    assign w_thief_pick  = rr_pick(w_is_thief, r_thief_ptr);
    assign w_victim_idx  = w_victim_pick[IDXW-1:0];

    always_comb begin
        w_half = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (IDXW'(k) == w_victim_idx) begin
                w_half = w_depth[k] >> 1;
            end
        end
        w_amount = (w_half > c_MAX_STEAL) ? c_MAX_STEAL : w_half;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_accept      = 1'b0;
        w_done_hit    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_victim_pick[IDXW] && w_thief_pick[IDXW]) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (steal_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A done arriving on the last timer cycle still counts as success.
                if (steal_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
                end else if (r_timer == c_TO_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (r_timer == c_CD_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_victim_ptr    <= '0;
            r_thief_ptr     <= '0;
            r_timer         <= '0;
            r_steal_from    <= '0;
            r_steal_to      <= '0;
            r_steal_amount  <= '0;
            r_steal_timeout <= 1'b0;
            r_steal_count   <= '0;
        end else begin
            r_steal_timeout <= w_timeout_hit;
            if (w_load) begin
                r_steal_from   <= w_victim_idx;
                r_steal_to     <= w_thief_pick[IDXW-1:0];
                r_steal_amount <= w_amount;
            end
            if (w_accept) begin
                r_victim_ptr <= (r_steal_from == c_LAST_IDX) ? '0 : r_steal_from + 1'b1;
                r_thief_ptr  <= (r_steal_to == c_LAST_IDX) ? '0 : r_steal_to + 1'b1;
            end
            if (w_done_hit && (r_steal_count != '1)) begin
                r_steal_count <= r_steal_count + 32'd1;
            end
            if (w_accept || w_done_hit || w_timeout_hit) begin
                r_timer <= '0;
            end else if ((r_state == S_WAIT_DONE) || (r_state == S_COOLDOWN)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign steal_valid   = (r_state == S_OFFER);
    assign busy          = (r_state != S_IDLE);
    assign steal_from    = r_steal_from;
    assign steal_to      = r_steal_to;
    assign steal_amount  = r_steal_amount;
    assign steal_timeout = r_steal_timeout;
    assign steal_count   = r_steal_count;

endmodule
`default_nettype wire

// File: tb/tb_work_stealing_scheduler_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_work_stealing_scheduler_rr
// Description : Directed self-checking bench for work_stealing_scheduler_rr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_work_stealing_scheduler_rr;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [159:0] depths;
    logic [9:0]   thr;
    logic         ready;
    logic         done;
    logic         valid;
    logic [3:0]   from_idx;
    logic [3:0]   to_idx;
    logic [9:0]   amt;
    logic         tmo;
    logic [31:0]  cnt;
    logic         busy;

    logic         en5;
    logic [49:0]  depths5;
    logic         ready5;
    logic         done5;
    logic         v5;
    logic [2:0]   from5;
    logic [2:0]   to5;
    logic [9:0]   amt5;
    logic         tmo5;
    logic [31:0]  cnt5;
    logic         busy5;

    int checks   = 0;
    int failures = 0;
    int exp_f [3] = '{2, 7, 2};
    int exp_t [3] = '{4, 11, 4};

    always #5 clk = ~clk;

    work_stealing_scheduler_rr dut (
        .clk(clk), .rst(rst), .enable(enable), .pe_queue_depths(depths),
        .dynamic_threshold(thr), .steal_valid(valid), .steal_ready(ready),
        .steal_from(from_idx), .steal_to(to_idx), .steal_amount(amt),
        .steal_done(done), .steal_timeout(tmo), .steal_count(cnt), .busy(busy)
    );

    work_stealing_scheduler_rr #(.NUM_PU(5)) dut5 (
        .clk(clk), .rst(rst), .enable(en5), .pe_queue_depths(depths5),
        .dynamic_threshold(thr), .steal_valid(v5), .steal_ready(ready5),
        .steal_from(from5), .steal_to(to5), .steal_amount(amt5),
        .steal_done(done5), .steal_timeout(tmo5), .steal_count(cnt5), .busy(busy5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int k, input logic [9:0] v);
        depths[k*10 +: 10] = v;
    endtask

    task automatic set_d5(input int k, input logic [9:0] v);
        depths5[k*10 +: 10] = v;
    endtask

    task automatic set_defaults;
        for (int k = 0; k < 16; k++) set_d(k, 10'd5);
        for (int k = 0; k < 5; k++) set_d5(k, 10'd5);
        thr = 10'd8; enable = 1'b0; ready = 1'b0; done = 1'b0;
        en5 = 1'b0; ready5 = 1'b0; done5 = 1'b0;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input bit sel5, input int bound, input string name);
        int n;
        n = 0;
        while (!(sel5 ? v5 : valid) && n < bound) begin
            tick;
            n++;
        end
        checks++;
        if ((sel5 ? v5 : valid) !== 1'b1) begin
            failures++;
            $display("FAIL %s: steal_valid never seen within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_idle(input bit sel5, input int bound, input string name);
        int n;
        n = 0;
        while ((sel5 ? busy5 : busy) && n < bound) begin
            tick;
            n++;
        end
        checks++;
        if ((sel5 ? busy5 : busy) !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy still high after %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset;
        int bad;
        set_defaults;
        enable = 1'b1;
        apply_reset;
        checks++;
        if ({valid, from_idx, to_idx, amt, tmo, cnt, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b from=%0d to=%0d amt=%0d tmo=%b cnt=%0d busy=%b, want all 0",
                     valid, from_idx, to_idx, amt, tmo, cnt, busy);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (valid !== 1'b0 || busy !== 1'b0 || tmo !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_no_steal: %0d cycles with activity, want 0", bad);
        end
    endtask

    task automatic test_basic_steal;
        set_defaults;
        apply_reset;
        set_d(3, 10'd40); set_d(9, 10'd0);
        ready = 1'b1; enable = 1'b1;
        checks++;
        if (valid !== 1'b0) begin
            failures++; $display("FAIL basic_pre_valid: got %b want 0", valid);
        end
        tick;
        checks++;
        if (valid !== 1'b1 || from_idx !== 4'd3 || to_idx !== 4'd9 || amt !== 10'd20) begin
            failures++;
            $display("FAIL basic_offer: got valid=%b from=%0d to=%0d amt=%0d want 1/3/9/20", valid, from_idx, to_idx, amt);
        end
        enable = 1'b0;
        tick;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_accept: got valid=%b busy=%b want 0/1", valid, busy);
        end
        repeat (9) tick;
        done = 1'b1;
        tick;
        done = 1'b0;
        checks++;
        if (cnt !== 32'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_count: got cnt=%0d busy=%b want 1/1", cnt, busy);
        end
        repeat (7) tick;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL basic_cooldown_hold: got busy=%b want 1", busy);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_cooldown_end: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        set_defaults;
        apply_reset;
        set_d(0, 10'd1000); set_d(5, 10'd0);
        enable = 1'b1;
        tick;
        checks++;
        if (valid !== 1'b1 || from_idx !== 4'd0 || to_idx !== 4'd5 || amt !== 10'd64) begin
            failures++;
            $display("FAIL clamp_offer: got valid=%b from=%0d to=%0d amt=%0d want 1/0/5/64", valid, from_idx, to_idx, amt);
        end
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            set_d(0, 10'(3 + i)); set_d(5, 10'(i + 1)); set_d(1, 10'd900); set_d(2, 10'd0);
            tick;
            if (valid !== 1'b1 || from_idx !== 4'd0 || to_idx !== 4'd5 || amt !== 10'd64) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
        end
        ready = 1'b1;
        tick;
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++; $display("FAIL backpressure_accept: got valid=%b want 0", valid);
        end
        done = 1'b1;
        tick;
        done = 1'b0;
        wait_idle(1'b0, 20, "backpressure_idle");
    endtask

    task automatic test_round_robin;
        set_defaults;
        apply_reset;
        set_d(2, 10'd50); set_d(7, 10'd50); set_d(4, 10'd0); set_d(11, 10'd0);
        enable = 1'b1; ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_valid(1'b0, 30, "rr_valid");
            checks++;
            if (from_idx !== 4'(exp_f[p]) || to_idx !== 4'(exp_t[p])) begin
                failures++;
                $display("FAIL rr_pair%0d: got (%0d,%0d) want (%0d,%0d)", p, from_idx, to_idx, exp_f[p], exp_t[p]);
            end
            tick;
            if (p == 2) enable = 1'b0;
            done = 1'b1;
            tick;
            done = 1'b0;
        end
        wait_idle(1'b0, 20, "rr_idle");
    endtask

    task automatic test_timeout;
        set_defaults;
        apply_reset;
        set_d(3, 10'd40); set_d(9, 10'd0);
        enable = 1'b1; ready = 1'b1;
        wait_valid(1'b0, 5, "to_valid");
        enable = 1'b0;
        tick;
        repeat (255) tick;
        checks++;
        if (tmo !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got tmo=%b want 0", tmo);
        end
        tick;
        checks++;
        if (tmo !== 1'b1 || cnt !== 32'd0) begin
            failures++; $display("FAIL timeout_pulse: got tmo=%b cnt=%0d want 1/0", tmo, cnt);
        end
        tick;
        checks++;
        if (tmo !== 1'b0) begin
            failures++; $display("FAIL timeout_width: got tmo=%b want 0", tmo);
        end
        wait_idle(1'b0, 20, "to_idle");
        enable = 1'b1;
        wait_valid(1'b0, 5, "coinc_valid");
        enable = 1'b0;
        tick;
        repeat (255) tick;
        done = 1'b1;
        tick;
        done = 1'b0;
        checks++;
        if (tmo !== 1'b0 || cnt !== 32'd1) begin
            failures++; $display("FAIL done_wins: got tmo=%b cnt=%0d want 0/1", tmo, cnt);
        end
        tick;
        checks++;
        if (tmo !== 1'b0) begin
            failures++; $display("FAIL done_wins_late: got tmo=%b want 0", tmo);
        end
        wait_idle(1'b0, 20, "coinc_idle");
    endtask

    task automatic test_npot_and_reset;
        int pulses;
        set_defaults;
        apply_reset;
        set_d5(4, 10'd40); set_d5(1, 10'd0);
        en5 = 1'b1; ready5 = 1'b1;
        wait_valid(1'b1, 5, "npot_valid");
        checks++;
        if (from5 !== 3'd4 || to5 !== 3'd1 || amt5 !== 10'd20) begin
            failures++; $display("FAIL npot_first: got from=%0d to=%0d amt=%0d want 4/1/20", from5, to5, amt5);
        end
        tick;
        done5 = 1'b1;
        tick;
        done5 = 1'b0;
        set_d5(0, 10'd40);
        wait_valid(1'b1, 20, "npot_valid2");
        checks++;
        if (from5 !== 3'd0 || to5 !== 3'd1) begin
            failures++; $display("FAIL npot_wrap: got (%0d,%0d) want (0,1)", from5, to5);
        end
        en5 = 1'b0;
        tick;
        tick;
        checks++;
        if (busy5 !== 1'b1 || v5 !== 1'b0 || cnt5 !== 32'd1) begin
            failures++; $display("FAIL npot_wait: got busy=%b valid=%b cnt=%0d want 1/0/1", busy5, v5, cnt5);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy5, v5, from5, to5, amt5, tmo5, cnt5} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b from=%0d to=%0d amt=%0d tmo=%b cnt=%0d want all 0",
                     busy5, v5, from5, to5, amt5, tmo5, cnt5);
        end
        tick;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (tmo5 !== 1'b0 || busy5 !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || cnt5 !== 32'd0) begin
            failures++; $display("FAIL midreset_quiet: got %0d active cycles cnt=%0d want 0/0", pulses, cnt5);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_defaults;
        test_reset;
        test_basic_steal;
        test_backpressure;
        test_round_robin;
        test_timeout;
        test_npot_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/work_stealing_scheduler_rr.md
Name: work_stealing_scheduler_rr

Overview:
Next-generation work-stealing scheduler for the BFS processing-unit array. It monitors per-PU frontier-queue depths and selects a victim/thief pair fairly using rotating round-robin pointers. It sizes the transfer, offers it to the distribution network over a valid/ready handshake, then tracks completion with a timeout and a post-steal cooldown. It sits between the PU queue-depth taps and the inter-PU frontier transfer network.

Parameters:
NUM_PU, 16, number of processing units; any value >= 2.
QUEUE_DEPTH_WIDTH, 10, width of each queue depth, the threshold and steal_amount.
MAX_STEAL, 64, upper bound on entries moved per steal; must fit in QUEUE_DEPTH_WIDTH.
TIMEOUT_CYCLES, 256, maximum number of cycles to wait for steal_done after acceptance; must be >= 1.
COOLDOWN_CYCLES, 8, idle cycles enforced after each completed or timed-out steal; 0 is legal.
IDXW, max(1,$clog2(NUM_PU)), derived width of a PU index. Not overridable.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  permits new steal selection.
pe_queue_depths  in  NUM_PU*QUEUE_DEPTH_WIDTH  flattened depths; PU k occupies bits [k*QDW +: QDW].
dynamic_threshold  in  QUEUE_DEPTH_WIDTH  victim threshold.
steal_valid  out  1  steal offer pending.
steal_ready  in  1  distribution network accepts the offer.
steal_from  out  IDXW  victim PU index.
steal_to  out  IDXW  thief PU index.
steal_amount  out  QUEUE_DEPTH_WIDTH  number of entries to move.
steal_done  in  1  transfer-complete pulse from the network.
steal_timeout  out  1  one-cycle pulse when a transfer times out.
steal_count  out  32  number of completed steals; saturates at all-ones.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset state: IDLE. All outputs 0. victim_ptr and thief_ptr 0. Timers 0.
- Reset mid-transaction: the transaction is abandoned silently. No timeout pulse is generated and steal_count holds its reset value.
- Victim candidate: depth > dynamic_threshold AND depth >= 2.
- Thief candidate: depth == 0.
- A victim and thief are therefore never the same PU.
- Victim selection: the first candidate at index >= victim_ptr, wrapping modulo NUM_PU. Thief selection uses the same rule with thief_ptr.
- steal_amount = min(depth[victim] >> 1, MAX_STEAL). It is computed from the depth sampled in the selection cycle and is always >= 1.
- Four states: IDLE, OFFER, WAIT_DONE, COOLDOWN.
- IDLE:
  - If enable is high and both a victim and a thief exist, latch steal_from, steal_to and steal_amount, and move to OFFER.
  - Depths sampled in cycle N produce steal_valid=1 in cycle N+1.
  - Otherwise remain in IDLE.
- OFFER:
  - steal_valid=1; steal_from, steal_to and steal_amount are held stable until accepted.
  - The offer is never withdrawn, even if enable drops or the depths change.
  - On steal_valid && steal_ready: steal_valid=0 next cycle, victim_ptr <= (steal_from+1) mod NUM_PU, thief_ptr <= (steal_to+1) mod NUM_PU, clear the timer, move to WAIT_DONE.
- WAIT_DONE:
  - The timer increments every cycle.
  - steal_done: increment steal_count (saturating) and move to COOLDOWN.
  - Timer reaching TIMEOUT_CYCLES-1 without done: steal_timeout=1 for exactly one cycle, move to COOLDOWN, steal_count unchanged.
  - If done and timeout coincide, done wins and no timeout pulse is issued.
- COOLDOWN:
  - Lasts exactly COOLDOWN_CYCLES cycles, then returns to IDLE.
  - With COOLDOWN_CYCLES=0 the FSM goes directly from WAIT_DONE to IDLE.
- steal_done asserted in any state other than WAIT_DONE is ignored.
- steal_from, steal_to and steal_amount retain their last values after a transaction.
- Pointer modulo must be correct for non-power-of-two NUM_PU: index NUM_PU-1 wraps to 0.

Test Plan:
1. Reset/idle: assert rst, then release; all depths 5, threshold 8 -> all outputs 0, busy=0, no steal_valid for 100 cycles.
2. Basic steal: NUM_PU=16, depth[3]=40, depth[9]=0, threshold 8, others 5, steal_ready=1 -> steal_valid one cycle after sampling with from=3, to=9, amount=20. Done 10 cycles later -> steal_count=1, busy drops after 8 cooldown cycles.
3. Backpressure and clamp: depth[0]=1000, steal_ready=0 for 20 cycles while depths change -> steal_valid held high with from, to and amount stable; amount=64 (clamped to MAX_STEAL).
4. Round-robin: depth[2]=depth[7]=50 and depth[4]=depth[11]=0 held constant, done returned promptly -> pairs (2,4), then (7,11), then (2,4).
5. Timeout: accept an offer, never assert done, TIMEOUT_CYCLES=256 -> steal_timeout pulses once 256 cycles after acceptance, steal_count unchanged. Done and timeout in the same cycle -> count increments and no pulse.
6. Non-power-of-two and mid-operation reset: NUM_PU=5 with a victim at 4 -> victim_ptr wraps to 0. Assert rst during WAIT_DONE -> immediate IDLE, outputs 0, no steal_timeout pulse.
